// File: rtl/bin_to_gray_counter_if.sv
// Request/result bundle between a producer and the binary/Gray pointer counter.
interface bin_to_gray_counter_if #(
   parameter int unsigned DataWidth = 4
);
   logic                 clear_i;
   logic                 load_en_i;
   logic [DataWidth-1:0] load_data_i;
   logic                 inc_i;
   logic [DataWidth-1:0] bin_o;
   logic [DataWidth-1:0] gray_o;
   logic                 wrap_o;

   // Producer side: issues requests, observes the count
   modport master (
      output clear_i,
      output load_en_i,
      output load_data_i,
      output inc_i,
      input  bin_o,
      input  gray_o,
      input  wrap_o
   );

   // Counter side
   modport slave (
      input  clear_i,
      input  load_en_i,
      input  load_data_i,
      input  inc_i,
      output bin_o,
      output gray_o,
      output wrap_o
   );
endinterface

// File: rtl/bin_to_gray_counter.sv
// Registered binary counter that also publishes its state as registered Gray code.
// gray_o comes straight from a flop so it is safe to synchronise into another
// clock domain; increments change exactly one bit of it, including the wrap.
module bin_to_gray_counter #(
   parameter int unsigned DataWidth = 4
) (
   input  logic                  clk_i,
   input  logic                  arst_ni,
   bin_to_gray_counter_if.slave  bus
);

   logic [DataWidth-1:0] bin_d;
   logic [DataWidth-1:0] bin_q;
   logic [DataWidth-1:0] gray_d;
   logic [DataWidth-1:0] gray_q;
   logic                 wrap_d;
   logic                 wrap_q;

   // Next state: clear > load > increment > hold; Gray derived from the next binary value
   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (bus.clear_i) begin
         bin_d = '0;
      end else if (bus.load_en_i) begin
         bin_d = bus.load_data_i;
      end else if (bus.inc_i) begin
         bin_d  = bin_q + DataWidth'(1);
         wrap_d = &bin_q;
      end
      gray_d = bin_d ^ (bin_d >> 1);
   end

   // Binary, Gray and wrap flops share one stage so they always agree
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.bin_o  = bin_q;
   assign bus.gray_o = gray_q;
   assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Directed and randomised checks for bin_to_gray_counter at DataWidth = 4.
module tb_bin_to_gray_counter;

   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   bin_to_gray_counter_if #(.DataWidth(W)) bus ();

   bin_to_gray_counter #(.DataWidth(W)) dut (
      .clk_i   (clk),
      .arst_ni (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic         clr;
      logic         ld;
      logic         inc;
      logic [W-1:0] data;
      logic [W-1:0] exp_bin;
      logic [W-1:0] exp_gray;
      logic         exp_wrap;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic drive(input logic c, input logic l, input logic n, input logic [W-1:0] d);
      bus.clear_i     = c;
      bus.load_en_i   = l;
      bus.inc_i       = n;
      bus.load_data_i = d;
   endtask

   // Apply the current inputs across one rising edge, return 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[16];

   initial begin
      logic [W-1:0] prev_gray;
      logic [W-1:0] model;
      logic [W-1:0] model_nxt;
      logic         model_wrap;
      int           wraps;
      logic         c, l, n;
      logic [W-1:0] d;

      // Sequence from reset value 0: {clr, ld, inc, data, bin, gray, wrap}
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd1,  4'b0001, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'd11, 4'd11, 4'b1110, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd3,  4'd11, 4'b1110, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd11, 4'b1110, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd6,  4'd11, 4'b1110, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd12, 4'b1010, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd5,  4'd5,  4'b0111, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd9,  4'd0,  4'b0000, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'd7,  4'd7,  4'b0100, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd15, 4'd15, 4'b1000, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 4'd15, 4'd15, 4'b1000, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  4'b0000, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd0,  4'b0000, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 4'd2,  4'd1,  4'b0001, 1'b0};

      drive(1'b0, 1'b0, 1'b0, '0);
      rst_n = 1'b0;
      #12;
      check("reset_bin",  32'(bus.bin_o),  32'd0);
      check("reset_gray", 32'(bus.gray_o), 32'd0);
      check("reset_wrap", 32'(bus.wrap_o), 32'd0);
      rst_n = 1'b1;
      tick();

      // Table-driven directed vectors
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].clr, vecs[i].ld, vecs[i].inc, vecs[i].data);
         tick();
         check($sformatf("vec%0d_bin", i),  32'(bus.bin_o),  32'(vecs[i].exp_bin));
         check($sformatf("vec%0d_gray", i), 32'(bus.gray_o), 32'(vecs[i].exp_gray));
         check($sformatf("vec%0d_wrap", i), 32'(bus.wrap_o), 32'(vecs[i].exp_wrap));
      end

      // Async reset mid-count at bin=9, no clock edge needed
      drive(1'b0, 1'b1, 1'b0, 4'd9);
      tick();
      drive(1'b0, 1'b0, 1'b1, '0);
      check("pre_rst_bin", 32'(bus.bin_o), 32'd9);
      rst_n = 1'b0;
      #2;
      check("async_rst_bin",  32'(bus.bin_o),  32'd0);
      check("async_rst_gray", 32'(bus.gray_o), 32'd0);
      check("async_rst_wrap", 32'(bus.wrap_o), 32'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_bin",  32'(bus.bin_o),  32'd1);
      check("post_rst_gray", 32'(bus.gray_o), 32'd1);

      // Full sweep: 32 increments from 0
      drive(1'b1, 1'b0, 1'b0, '0);
      tick();
      drive(1'b0, 1'b0, 1'b1, '0);
      prev_gray = bus.gray_o;
      model     = '0;
      wraps     = 0;
      for (int i = 0; i < 32; i++) begin
         tick();
         model = model + 4'd1;
         check("sweep_bin",  32'(bus.bin_o),  32'(model));
         check("sweep_gray", 32'(bus.gray_o), 32'(model ^ (model >> 1)));
         check("sweep_onebit", 32'($countones(bus.gray_o ^ prev_gray)), 32'd1);
         check("sweep_decode", 32'(g2b(bus.gray_o)), 32'(bus.bin_o));
         check("sweep_wrap", 32'(bus.wrap_o), 32'(model == 4'd0));
         if (bus.wrap_o) wraps++;
         prev_gray = bus.gray_o;
      end
      check("sweep_wrap_count", 32'(wraps), 32'd2);

      // Randomised run with sporadic async resets
      drive(1'b1, 1'b0, 1'b0, '0);
      tick();
      model = '0;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            #2;
            check("rnd_rst_bin",  32'(bus.bin_o),  32'd0);
            check("rnd_rst_wrap", 32'(bus.wrap_o), 32'd0);
            rst_n = 1'b1;
            model = '0;
         end
         c = ($urandom_range(0, 15) == 0);
         l = ($urandom_range(0, 7) == 0);
         n = ($urandom_range(0, 3) != 0);
         d = W'($urandom);
         drive(c, l, n, d);
         model_wrap = 1'b0;
         if (c)      model_nxt = '0;
         else if (l) model_nxt = d;
         else if (n) begin
            model_nxt  = model + 4'd1;
            model_wrap = (model == 4'hF);
         end
         else        model_nxt = model;
         tick();
         model = model_nxt;
         check("rnd_bin",  32'(bus.bin_o),  32'(model));
         check("rnd_gray", 32'(bus.gray_o), 32'(bus.bin_o ^ (bus.bin_o >> 1)));
         check("rnd_wrap", 32'(bus.wrap_o), 32'(model_wrap));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
